burst_ram_arbiter: RTL

- Shares one burst RAM command/data interface between two requesters, A and B. Typical pairing: instruction cache and data cache.
- Serialises commands with round-robin arbitration.
- Enforces the RAM's minimum command-to-command interval across both requesters.
- Forwards write beats from the owning requester and steers read beats back to it.
- Sits between the cache instances and the PSRAM controller IP.

---
 rtl/burst_ram_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one burst RAM command/data port between two
// requesters (A, B) with round-robin arbitration, a minimum command-to-command
// interval, write-beat forwarding and read-beat steering to the burst owner.
// Optional read-data timeout: define BURST_RAM_ARBITER_TIMEOUT_EN.
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH     = 21,
  parameter int COMMAND_DELAY_INTERVAL = 20,
  parameter int BURST_BEATS            = 4,
  parameter int TIMEOUT_CYCLES         = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_cmd,
  input  logic                          a_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] a_addr,
  input  logic [63:0]                   a_wr_data,
  output logic                          a_cmd_ack,
  output logic [63:0]                   a_rd_data,
  output logic                          a_rd_data_valid,
  input  logic                          b_cmd,
  input  logic                          b_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] b_addr,
  input  logic [63:0]                   b_wr_data,
  output logic                          b_cmd_ack,
  output logic [63:0]                   b_rd_data,
  output logic                          b_rd_data_valid,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid,
  output logic                          error
);

  localparam int CW = $clog2(COMMAND_DELAY_INTERVAL + 1);
  localparam int BW = $clog2(BURST_BEATS + 1);

  // The beat counter logic assumes at least two beats per burst.
  if (BURST_BEATS < 2) begin : g_chk_beats
    $error("BURST_BEATS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE        = 4'b0001,
    WRITE_BEATS = 4'b0010,
    READ_WAIT   = 4'b0100,
    READ_BEATS  = 4'b1000
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic                          last_q, last_d;    // 1: B was granted last
  logic                          owner_q, owner_d;  // 1: B owns the burst
  logic                          br_cmd_q, br_cmd_d;
  logic                          br_cmd_en_q, br_cmd_en_d;
  logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q, br_addr_d;
  logic [63:0]                   br_wr_data_q, br_wr_data_d;
  logic                          a_ack_q, a_ack_d;
  logic                          b_ack_q, b_ack_d;
  logic                          err_q, err_d;
  logic                          rd_phase, rd_vld, win_b;

`ifdef BURST_RAM_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign rd_phase        = (state_q == READ_WAIT) || (state_q == READ_BEATS);
  assign rd_vld          = rd_phase & br_rd_data_valid;
  assign a_rd_data       = br_rd_data;
  assign b_rd_data       = br_rd_data;
  assign a_rd_data_valid = rd_vld & ~owner_q;
  assign b_rd_data_valid = rd_vld & owner_q;
  // B wins only if A is idle or A was the last one served.
  assign win_b           = b_cmd_en & (~a_cmd_en | ~last_q);

  assign br_cmd       = br_cmd_q;
  assign br_cmd_en    = br_cmd_en_q;
  assign br_addr      = br_addr_q;
  assign br_wr_data   = br_wr_data_q;
  assign br_data_mask = 8'h00;
  assign a_cmd_ack    = a_ack_q;
  assign b_cmd_ack    = b_ack_q;
  assign error        = err_q;

  // Next-state: arbitration, issue, beat counting, command interval.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    beat_d       = beat_q;
    last_d       = last_q;
    owner_d      = owner_q;
    br_cmd_d     = br_cmd_q;
    br_cmd_en_d  = 1'b0;
    br_addr_d    = br_addr_q;
    br_wr_data_d = br_wr_data_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    err_d        = 1'b0;
`ifdef BURST_RAM_ARBITER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if ((cnt_q == '0) && (a_cmd_en || b_cmd_en)) begin
          cnt_d        = CW'(COMMAND_DELAY_INTERVAL);
          br_cmd_en_d  = 1'b1;
          owner_d      = win_b;
          last_d       = win_b;
          br_cmd_d     = win_b ? b_cmd     : a_cmd;
          br_addr_d    = win_b ? b_addr    : a_addr;
          br_wr_data_d = win_b ? b_wr_data : a_wr_data;
          a_ack_d      = ~win_b;
          b_ack_d      = win_b;
          beat_d       = '0;
          state_d      = (win_b ? b_cmd : a_cmd) ? WRITE_BEATS : READ_WAIT;
        end
      end
      WRITE_BEATS: begin
        br_wr_data_d = owner_q ? b_wr_data : a_wr_data;
        if (beat_q == BW'(BURST_BEATS - 2)) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      READ_WAIT: begin
        if (br_rd_data_valid) begin
          beat_d  = BW'(1);
          state_d = READ_BEATS;
        end
      end
      READ_BEATS: begin
        if (br_rd_data_valid) begin
          if (beat_q == BW'(BURST_BEATS - 1)) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BURST_RAM_ARBITER_TIMEOUT_EN
    // Abandon a read whose beats stop arriving; the command interval still runs.
    if (rd_phase) begin
      if (br_rd_data_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        beat_d  = '0;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      br_cmd_q     <= 1'b0;
      br_cmd_en_q  <= 1'b0;
      br_addr_q    <= '0;
      br_wr_data_q <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef BURST_RAM_ARBITER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      br_cmd_q     <= br_cmd_d;
      br_cmd_en_q  <= br_cmd_en_d;
      br_addr_q    <= br_addr_d;
      br_wr_data_q <= br_wr_data_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      err_q        <= err_d;
`ifdef BURST_RAM_ARBITER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

endmodule
